// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised up/down counter family.
package counter_pkg;

   typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} cnt_mode_e;

   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation for one counting step, with
// boundary-crossing detection for wrap and saturate modes.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MOD   = 2**WIDTH
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] s,
   input  logic             up_down,
   input  cnt_mode_e        mode,
   output logic [WIDTH-1:0] next_count,
   output logic             wrap_hit,
   output logic             sat_hit
);

   // One extra bit so count+s and count+MOD never overflow.
   localparam logic [WIDTH:0] MODV = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MOD - 1);

   logic [WIDTH:0] cnt_x;
   logic [WIDTH:0] s_x;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] nxt;

   assign cnt_x = {1'b0, count};
   assign s_x   = {1'b0, s};
   assign sum   = cnt_x + s_x;

   // NOTE: every output of always_comb gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      nxt      = cnt_x;
      wrap_hit = 1'b0;
      sat_hit  = 1'b0;
      if (up_down == UP) begin
         if (sum > MAXV) begin
            if (mode == MODE_WRAP) begin
               nxt      = sum - MODV;
               wrap_hit = 1'b1;
            end else begin
               nxt     = MAXV;
               sat_hit = 1'b1;
            end
         end else begin
            nxt = sum;
         end
      end else begin
         if (s_x > cnt_x) begin
            if (mode == MODE_WRAP) begin
               nxt      = cnt_x + MODV - s_x;
               wrap_hit = 1'b1;
            end else begin
               nxt     = '0;
               sat_hit = 1'b1;
            end
         end else begin
            nxt = cnt_x - s_x;
         end
      end
   end

   assign next_count = nxt[WIDTH-1:0];

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised modulo up/down counter with programmable step, parallel load,
// wrap/saturate modes, terminal-count flags and registered event pulses.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MOD    = 2**WIDTH,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up_down,
   input  cnt_mode_e         mode,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   output logic [WIDTH-1:0]  count,
   output logic              tc_max,
   output logic              tc_min,
   output logic              wrap_evt,
   output logic              sat_evt,
   output logic              load_err
);

   if (MOD < 2 || MOD > 2**WIDTH) begin : g_bad_mod
      $error("param_updown_counter: MOD=%0d outside 2..2**WIDTH", MOD);
   end

   localparam logic [WIDTH-1:0] MAXC = WIDTH'(MOD - 1);
   localparam int unsigned      SW   = (STEP_W > WIDTH) ? STEP_W : WIDTH;
   localparam logic [SW-1:0]    MAXS = SW'(MOD - 1);

   logic [SW-1:0]    step_x;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] next_count;
   logic             wrap_hit;
   logic             sat_hit;
   logic             load_over;

   // Steps larger than a full revolution are clamped to MOD-1.
   assign step_x    = SW'(step);
   assign s         = (step_x > MAXS) ? MAXC : WIDTH'(step_x);
   assign load_over = (load_val > MAXC);

   counter_next_calc #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_next (
      .count      (count),
      .s          (s),
      .up_down    (up_down),
      .mode       (mode),
      .next_count (next_count),
      .wrap_hit   (wrap_hit),
      .sat_hit    (sat_hit)
   );

   // NOTE: registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count    <= '0;
         wrap_evt <= 1'b0;
         sat_evt  <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         count    <= load_over ? MAXC : load_val;
         load_err <= load_over;
         wrap_evt <= 1'b0;
         sat_evt  <= 1'b0;
      end else if (en) begin
         count    <= next_count;
         wrap_evt <= wrap_hit;
         sat_evt  <= sat_hit;
         load_err <= 1'b0;
      end else begin
         wrap_evt <= 1'b0;
         sat_evt  <= 1'b0;
         load_err <= 1'b0;
      end
   end

   assign tc_max = (count == MAXC);
   assign tc_min = (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter (WIDTH=4, MOD=10): directed
// scenarios plus randomized traffic against an integer reference model.
module tb_param_updown_counter;
   import counter_pkg::*;

   localparam int WIDTH  = 4;
   localparam int MOD    = 10;
   localparam int STEP_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              up_down;
   cnt_mode_e         mode;
   logic [STEP_W-1:0] step;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  count;
   logic              tc_max;
   logic              tc_min;
   logic              wrap_evt;
   logic              sat_evt;
   logic              load_err;

   always #5 clk = ~clk;

   param_updown_counter #(
      .WIDTH  (WIDTH),
      .MOD    (MOD),
      .STEP_W (STEP_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_down  (up_down),
      .mode     (mode),
      .step     (step),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc_max   (tc_max),
      .tc_min   (tc_min),
      .wrap_evt (wrap_evt),
      .sat_evt  (sat_evt),
      .load_err (load_err)
   );

   typedef struct {
      int count;
      bit tmax;
      bit tmin;
      bit wrap;
      bit sat;
      bit err;
   } exp_t;

   exp_t sb_q[$];
   int   m_count = 0;
   int   errors  = 0;
   int   checks  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: signed integer arithmetic, then fold back into range.
   function automatic exp_t model(input bit r, input bit e, input bit ud, input cnt_mode_e md,
                                  input int st, input bit ld, input int lv);
      exp_t x;
      int   s;
      int   t;
      x = '{count: m_count, tmax: 0, tmin: 0, wrap: 0, sat: 0, err: 0};
      if (!r) begin
         x.count = 0;
      end else if (ld) begin
         if (lv > MOD - 1) begin
            x.count = MOD - 1;
            x.err   = 1;
         end else begin
            x.count = lv;
         end
      end else if (e) begin
         s = (st > MOD - 1) ? MOD - 1 : st;
         t = ud ? m_count + s : m_count - s;
         if (t >= 0 && t <= MOD - 1) begin
            x.count = t;
         end else if (md == MODE_WRAP) begin
            x.count = ((t % MOD) + MOD) % MOD;
            x.wrap  = 1;
         end else begin
            x.count = (t < 0) ? 0 : MOD - 1;
            x.sat   = 1;
         end
      end
      x.tmax = (x.count == MOD - 1);
      x.tmin = (x.count == 0);
      return x;
   endfunction

   // Apply inputs from a falling edge, record the expectation at the rising
   // edge, and return on the next falling edge.
   task automatic drive(input bit r, input bit e, input bit ud, input cnt_mode_e md,
                        input int st, input bit ld, input int lv);
      exp_t x;
      rst      = r;
      en       = e;
      up_down  = ud;
      mode     = md;
      step     = STEP_W'(st);
      load     = ld;
      load_val = WIDTH'(lv);
      @(posedge clk);
      x       = model(r, e, ud, md, st, ld, lv);
      m_count = x.count;
      sb_q.push_back(x);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (sb_q.size() > 0) begin
         x = sb_q.pop_front();
         check("count",    32'(count),    32'(x.count));
         check("tc_max",   32'(tc_max),   32'(x.tmax));
         check("tc_min",   32'(tc_min),   32'(x.tmin));
         check("wrap_evt", 32'(wrap_evt), 32'(x.wrap));
         check("sat_evt",  32'(sat_evt),  32'(x.sat));
         check("load_err", 32'(load_err), 32'(x.err));
      end
   end

   initial begin
      rst = 1'b0; en = 1'b0; up_down = UP; mode = MODE_WRAP;
      step = '0; load = 1'b0; load_val = '0;

      // Reset held with a pending step, then released.
      drive(0, 1, UP, MODE_WRAP, 3, 0, 0);
      drive(0, 1, UP, MODE_WRAP, 3, 0, 0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_tc_min", 32'(tc_min), 32'd1);
      drive(1, 1, UP, MODE_WRAP, 3, 0, 0);
      check("release_count", 32'(count), 32'd3);

      // Wrap up: 8 -> 1 (event) -> 4.
      drive(1, 0, UP, MODE_WRAP, 0, 1, 8);
      drive(1, 1, UP, MODE_WRAP, 3, 0, 0);
      check("wrap_up_count", 32'(count), 32'd1);
      check("wrap_up_evt", 32'(wrap_evt), 32'd1);
      drive(1, 1, UP, MODE_WRAP, 3, 0, 0);
      check("wrap_up_next", 32'(count), 32'd4);
      check("wrap_up_evt_clr", 32'(wrap_evt), 32'd0);

      // Wrap down: 1 -> 8, then step 12 clamps to 9: 8 -> 9.
      drive(1, 0, DOWN, MODE_WRAP, 0, 1, 1);
      drive(1, 1, DOWN, MODE_WRAP, 3, 0, 0);
      check("wrap_down_count", 32'(count), 32'd8);
      drive(1, 1, DOWN, MODE_WRAP, 12, 0, 0);
      check("wrap_down_clamp", 32'(count), 32'd9);

      // Saturate up from 7, continue at the top, then saturate down from 5.
      drive(1, 0, UP, MODE_SAT, 0, 1, 7);
      drive(1, 1, UP, MODE_SAT, 4, 0, 0);
      drive(1, 1, UP, MODE_SAT, 4, 0, 0);
      check("sat_hold_count", 32'(count), 32'd9);
      check("sat_hold_evt", 32'(sat_evt), 32'd1);
      drive(1, 0, DOWN, MODE_SAT, 0, 1, 5);
      drive(1, 1, DOWN, MODE_SAT, 15, 0, 0);
      check("sat_down_count", 32'(count), 32'd0);

      // Load beats enable; out-of-range load clips and flags.
      drive(1, 1, UP, MODE_WRAP, 3, 1, 12);
      check("load_err_count", 32'(count), 32'd9);
      check("load_err_flag", 32'(load_err), 32'd1);
      drive(1, 1, UP, MODE_WRAP, 3, 1, 0);
      check("load_zero_err", 32'(load_err), 32'd0);

      // Mid-count reset at 6, then hold with en=0.
      drive(1, 0, UP, MODE_WRAP, 0, 1, 4);
      drive(1, 1, UP, MODE_WRAP, 1, 0, 0);
      drive(1, 1, UP, MODE_WRAP, 1, 0, 0);
      drive(0, 1, UP, MODE_WRAP, 1, 0, 0);
      check("mid_reset_count", 32'(count), 32'd0);
      drive(1, 1, UP, MODE_WRAP, 2, 0, 0);
      drive(1, 0, UP, MODE_SAT, 5, 0, 0);
      drive(1, 0, DOWN, MODE_WRAP, 5, 0, 0);
      check("hold_count", 32'(count), 32'd2);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 39) != 0,
               $urandom_range(0, 4) != 0,
               1'($urandom_range(0, 1)),
               cnt_mode_e'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)),
               $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 15)));
      end

      @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
